led_anim_seq: RTL and testbench

Playback sequencer for the LED animation pattern ROMs. It generates the 7-bit frame index that drives a combinational pattern decoder (128 frames, 7-bit active-low LED word per frame) at a programmable frame rate. It registers the decoder output onto the LED pins. It supports play, pause, single-step, reverse and loop/one-shot modes, and sits between the board control inputs and the pattern decoder.

---
 rtl/led_anim_seq.sv | 168 ++++++++++++++++
 tb/tb_led_anim_seq.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_anim_seq.sv
// led_anim_seq: playback sequencer for the LED animation pattern ROMs.
// Walks a 7-bit frame index at a programmable frame rate, registers the
// decoder's active-low LED word, and supports play/pause/step/reverse/loop.
module led_anim_seq #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             step,
  input  logic             dir,
  input  logic             loop,
  input  logic [DIV_W-1:0] div,
  input  logic [6:0]       pat,
  output logic [6:0]       idx,
  output logic [6:0]       led,
  output logic             busy,
  output logic             frame_tick,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [6:0]       r_idx;
  logic [6:0]       r_led;
  logic             r_tick;
  logic             r_done;

  state_t           w_nextState;
  logic [DIV_W-1:0] w_nextCnt;
  logic [6:0]       w_nextIdx;
  logic [6:0]       w_nextLed;
  logic             w_nextTick;
  logic             w_nextDone;
  logic             w_advance;
  logic             w_atEnd;
  logic             w_cntHit;
  logic [6:0]       w_idxStep;
  logic [6:0]       w_idxLoad;

  // 7-bit arithmetic wraps 127->0 and 0->127 on its own, which is exactly the loop behaviour
  assign w_atEnd   = dir ? (r_idx == 7'd0) : (r_idx == 7'd127);
  assign w_idxStep = dir ? (r_idx - 7'd1) : (r_idx + 7'd1);
  assign w_idxLoad = dir ? 7'd127 : 7'd0;
  assign w_cntHit  = (r_cnt >= div);

  // Next-state logic: pick the state action first, then resolve advances, then let stop override everything
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextIdx   = r_idx;
    w_nextTick  = 1'b0;
    w_nextDone  = 1'b0;
    w_advance   = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_nextCnt = '0;
        w_nextIdx = 7'd0;
        if (start) begin
          w_nextState = RUN;
          w_nextIdx   = w_idxLoad;
        end
      end
      RUN: begin
        if (start) begin
          w_nextCnt = '0;
          w_nextIdx = w_idxLoad;
        end else if (pause) begin
          w_nextState = PAUSE;
        end else if (w_cntHit) begin
          w_nextCnt = '0;
          w_advance = 1'b1;
        end else begin
          w_nextCnt = r_cnt + DIV_W'(1);
        end
      end
      PAUSE: begin
        if (start) begin
          w_nextState = RUN;
          w_nextCnt   = '0;
          w_nextIdx   = w_idxLoad;
        end else if (step) begin
          w_advance = 1'b1;
        end else if (!pause) begin
          w_nextState = RUN;
          if (w_cntHit) begin
            w_nextCnt = '0;
            w_advance = 1'b1;
          end else begin
            w_nextCnt = r_cnt + DIV_W'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          w_nextState = RUN;
          w_nextCnt   = '0;
          w_nextIdx   = w_idxLoad;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase

    if (w_advance) begin
      if (w_atEnd && !loop) begin
        w_nextState = DONE;
        w_nextDone  = 1'b1;
      end else begin
        w_nextIdx  = w_idxStep;
        w_nextTick = 1'b1;
      end
    end

    if (stop) begin
      w_nextState = IDLE;
      w_nextCnt   = '0;
      w_nextIdx   = 7'd0;
      w_nextTick  = 1'b0;
      w_nextDone  = 1'b0;
    end
  end

  // LEDs are dark whenever we are in or entering IDLE, otherwise they follow the decoder one clock behind idx
  always_comb begin
    w_nextLed = pat;
    if (r_state == IDLE || w_nextState == IDLE) begin
      w_nextLed = 7'h7F;
    end
  end

  // Sequencer state, prescaler, index and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= 7'd0;
      r_led   <= 7'h7F;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_idx   <= w_nextIdx;
      r_led   <= w_nextLed;
      r_tick  <= w_nextTick;
      r_done  <= w_nextDone;
    end
  end

  assign idx        = r_idx;
  assign led        = r_led;
  assign busy       = (r_state == RUN) || (r_state == PAUSE);
  assign frame_tick = r_tick;
  assign done       = r_done;

endmodule

// File: tb/tb_led_anim_seq.sv
// tb_led_anim_seq: directed table-driven bench for led_anim_seq with a
// stand-in decoder (pat = idx ^ 7'h33, so idx 5 maps to 7'b0110110).
module tb_led_anim_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        pause;
  logic        step;
  logic        dir;
  logic        loop;
  logic [23:0] div;
  logic [6:0]  pat;
  logic [6:0]  idx;
  logic [6:0]  led;
  logic        busy;
  logic        frame_tick;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        pause;
    logic        step;
    logic        dir;
    logic        loop;
    logic [23:0] div;
    logic [6:0]  expIdx;
    logic [6:0]  expLed;
    logic        expBusy;
    logic        expTick;
    logic        expDone;
  } vec_t;

  vec_t       vecs[20];
  logic [6:0] expIdx;

  led_anim_seq #(.DIV_W(24)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .step       (step),
    .dir        (dir),
    .loop       (loop),
    .div        (div),
    .pat        (pat),
    .idx        (idx),
    .led        (led),
    .busy       (busy),
    .frame_tick (frame_tick),
    .done       (done)
  );

  // Stand-in pattern decoder, combinational from idx
  assign pat = idx ^ 7'h33;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t makeVec(input logic s, input logic sp, input logic p, input logic st,
                                   input logic d, input logic l, input logic [23:0] dv,
                                   input logic [6:0] ei, input logic [6:0] el,
                                   input logic eb, input logic et, input logic ed);
    vec_t v;
    v.start = s; v.stop = sp; v.pause = p; v.step = st; v.dir = d; v.loop = l; v.div = dv;
    v.expIdx = ei; v.expLed = el; v.expBusy = eb; v.expTick = et; v.expDone = ed;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    start = 1'b0; stop = 1'b0; pause = 1'b0; step = 1'b0;
  endtask

  task automatic resetDut();
    clearInputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulseStart();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    start = v.start; stop = v.stop; pause = v.pause; step = v.step;
    dir = v.dir; loop = v.loop; div = v.div;
    tick();
    checkOutput($sformatf("vec%0d idx", n), 32'(idx), 32'(v.expIdx));
    checkOutput($sformatf("vec%0d led", n), 32'(led), 32'(v.expLed));
    checkOutput($sformatf("vec%0d busy", n), 32'(busy), 32'(v.expBusy));
    checkOutput($sformatf("vec%0d tick", n), 32'(frame_tick), 32'(v.expTick));
    checkOutput($sformatf("vec%0d done", n), 32'(done), 32'(v.expDone));
  endtask

  initial begin
    //                  start stop pause step dir loop div   idx      led     busy tick done
    vecs[0]  = makeVec(0, 0, 0, 0, 0, 1, 24'd1, 7'd0,   7'h7F, 0, 0, 0);
    vecs[1]  = makeVec(1, 0, 0, 0, 0, 1, 24'd1, 7'd0,   7'h7F, 1, 0, 0);
    vecs[2]  = makeVec(0, 0, 0, 0, 0, 1, 24'd1, 7'd0,   7'h33, 1, 0, 0);
    vecs[3]  = makeVec(0, 0, 0, 0, 0, 1, 24'd1, 7'd1,   7'h33, 1, 1, 0);
    vecs[4]  = makeVec(0, 0, 0, 0, 0, 1, 24'd1, 7'd1,   7'h32, 1, 0, 0);
    vecs[5]  = makeVec(0, 0, 1, 0, 0, 1, 24'd1, 7'd1,   7'h32, 1, 0, 0);
    vecs[6]  = makeVec(0, 0, 1, 1, 0, 1, 24'd1, 7'd2,   7'h32, 1, 1, 0);
    vecs[7]  = makeVec(0, 0, 1, 0, 0, 1, 24'd1, 7'd2,   7'h31, 1, 0, 0);
    vecs[8]  = makeVec(0, 0, 0, 0, 0, 1, 24'd1, 7'd3,   7'h31, 1, 1, 0);
    vecs[9]  = makeVec(0, 0, 0, 0, 1, 1, 24'd1, 7'd3,   7'h30, 1, 0, 0);
    vecs[10] = makeVec(0, 0, 0, 0, 1, 1, 24'd1, 7'd2,   7'h30, 1, 1, 0);
    vecs[11] = makeVec(1, 1, 0, 0, 1, 1, 24'd1, 7'd0,   7'h7F, 0, 0, 0);
    vecs[12] = makeVec(0, 0, 0, 1, 1, 1, 24'd1, 7'd0,   7'h7F, 0, 0, 0);
    vecs[13] = makeVec(1, 0, 0, 0, 1, 1, 24'd1, 7'd127, 7'h7F, 1, 0, 0);
    vecs[14] = makeVec(0, 0, 0, 0, 1, 1, 24'd0, 7'd126, 7'h4C, 1, 1, 0);
    vecs[15] = makeVec(0, 0, 0, 0, 1, 0, 24'd0, 7'd125, 7'h4D, 1, 1, 0);
    vecs[16] = makeVec(1, 0, 0, 0, 0, 0, 24'd0, 7'd0,   7'h4E, 1, 0, 0);
    vecs[17] = makeVec(0, 0, 0, 0, 1, 0, 24'd0, 7'd0,   7'h33, 0, 0, 1);
    vecs[18] = makeVec(0, 0, 1, 1, 1, 0, 24'd0, 7'd0,   7'h33, 0, 0, 0);
    vecs[19] = makeVec(0, 1, 0, 0, 1, 0, 24'd0, 7'd0,   7'h7F, 0, 0, 0);

    dir = 1'b0; loop = 1'b1; div = 24'd1;
    resetDut();
    checkOutput("reset idx", 32'(idx), 32'd0);
    checkOutput("reset led", 32'(led), 32'h7F);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset tick", 32'(frame_tick), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);

    for (int i = 0; i < 20; i++) applyStimulus(vecs[i], i);
    clearInputs();

    // Forward one-shot, div=3: 4 clocks per frame, done at clock 512
    resetDut();
    div = 24'd3; dir = 1'b0; loop = 1'b0;
    pulseStart();
    for (int k = 1; k <= 511; k++) begin
      tick();
      checkOutput($sformatf("fwd idx k=%0d", k), 32'(idx), 32'(k / 4));
      checkOutput($sformatf("fwd tick k=%0d", k), 32'(frame_tick), 32'((k % 4) == 0));
      checkOutput($sformatf("fwd done k=%0d", k), 32'(done), 32'd0);
      if (k == 21) checkOutput("fwd led for idx5", 32'(led), 32'b0110110);
    end
    tick();
    checkOutput("fwd done pulse", 32'(done), 32'd1);
    checkOutput("fwd end idx", 32'(idx), 32'd127);
    checkOutput("fwd end busy", 32'(busy), 32'd0);
    checkOutput("fwd end tick", 32'(frame_tick), 32'd0);
    tick();
    checkOutput("fwd done once", 32'(done), 32'd0);
    checkOutput("fwd idx held", 32'(idx), 32'd127);

    // Reverse loop, div=0: one frame per clock and wraps 0->127
    resetDut();
    div = 24'd0; dir = 1'b1; loop = 1'b1;
    pulseStart();
    checkOutput("rev load idx", 32'(idx), 32'd127);
    expIdx = 7'd127;
    for (int k = 1; k <= 129; k++) begin
      tick();
      expIdx = expIdx - 7'd1;
      checkOutput($sformatf("rev idx k=%0d", k), 32'(idx), 32'(expIdx));
      checkOutput($sformatf("rev tick k=%0d", k), 32'(frame_tick), 32'd1);
      checkOutput($sformatf("rev done k=%0d", k), 32'(done), 32'd0);
    end

    // Pause at idx=10/cnt=2, three steps, then resume from the frozen count
    resetDut();
    div = 24'd3; dir = 1'b0; loop = 1'b1;
    pulseStart();
    for (int k = 1; k <= 42; k++) tick();
    checkOutput("pause pre idx", 32'(idx), 32'd10);
    pause = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("pause hold idx %0d", k), 32'(idx), 32'd10);
      checkOutput($sformatf("pause hold busy %0d", k), 32'(busy), 32'd1);
    end
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      checkOutput($sformatf("step%0d idx", s), 32'(idx), 32'(11 + s));
      checkOutput($sformatf("step%0d tick", s), 32'(frame_tick), 32'd1);
      tick();
      checkOutput($sformatf("step%0d gap idx", s), 32'(idx), 32'(11 + s));
      checkOutput($sformatf("step%0d gap tick", s), 32'(frame_tick), 32'd0);
    end
    pause = 1'b0;
    tick();
    checkOutput("resume1 idx", 32'(idx), 32'd13);
    checkOutput("resume1 tick", 32'(frame_tick), 32'd0);
    tick();
    checkOutput("resume2 idx", 32'(idx), 32'd14);
    checkOutput("resume2 tick", 32'(frame_tick), 32'd1);

    // Start during DONE restarts with a cleared prescaler
    resetDut();
    div = 24'd0; dir = 1'b1; loop = 1'b0;
    pulseStart();
    for (int k = 1; k <= 128; k++) tick();
    checkOutput("done state pulse", 32'(done), 32'd1);
    checkOutput("done state busy", 32'(busy), 32'd0);
    div = 24'd2; dir = 1'b0;
    pulseStart();
    checkOutput("restart idx", 32'(idx), 32'd0);
    checkOutput("restart busy", 32'(busy), 32'd1);
    tick();
    tick();
    checkOutput("restart hold idx", 32'(idx), 32'd0);
    tick();
    checkOutput("restart adv idx", 32'(idx), 32'd1);
    checkOutput("restart adv tick", 32'(frame_tick), 32'd1);

    // Lowering div below the running count forces an advance on the next clock
    resetDut();
    div = 24'd100; dir = 1'b0; loop = 1'b1;
    pulseStart();
    for (int k = 1; k <= 50; k++) tick();
    checkOutput("divchg pre idx", 32'(idx), 32'd0);
    div = 24'd10;
    tick();
    checkOutput("divchg adv idx", 32'(idx), 32'd1);
    checkOutput("divchg adv tick", 32'(frame_tick), 32'd1);
    for (int k = 0; k < 10; k++) begin
      tick();
      checkOutput($sformatf("divchg gap tick %0d", k), 32'(frame_tick), 32'd0);
    end
    tick();
    checkOutput("divchg next idx", 32'(idx), 32'd2);
    checkOutput("divchg next tick", 32'(frame_tick), 32'd1);

    // Asynchronous reset between edges mid-run
    resetDut();
    div = 24'd0; dir = 1'b0; loop = 1'b1;
    pulseStart();
    for (int k = 1; k <= 5; k++) tick();
    checkOutput("areset pre idx", 32'(idx), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset idx", 32'(idx), 32'd0);
    checkOutput("areset led", 32'(led), 32'h7F);
    checkOutput("areset busy", 32'(busy), 32'd0);
    checkOutput("areset tick", 32'(frame_tick), 32'd0);
    checkOutput("areset done", 32'(done), 32'd0);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput($sformatf("post reset idx %0d", k), 32'(idx), 32'd0);
      checkOutput($sformatf("post reset busy %0d", k), 32'(busy), 32'd0);
      checkOutput($sformatf("post reset led %0d", k), 32'(led), 32'h7F);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
